// File: rtl/ysyx22041405_idu_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx22041405_idu_pipe_pkg                                                  |
// | Shared opcode constants, format codes and parameter legality helpers.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package ysyx22041405_idu_pipe_pkg;

    typedef enum logic [2:0] {
        c_fmt_r   = 3'd0,
        c_fmt_i   = 3'd1,
        c_fmt_s   = 3'd2,
        c_fmt_b   = 3'd3,
        c_fmt_u   = 3'd4,
        c_fmt_j   = 3'd5,
        c_fmt_ill = 3'd7
    } fmt_e;

    localparam logic [6:0] c_op_lui      = 7'b0110111;
    localparam logic [6:0] c_op_auipc    = 7'b0010111;
    localparam logic [6:0] c_op_jal      = 7'b1101111;
    localparam logic [6:0] c_op_jalr     = 7'b1100111;
    localparam logic [6:0] c_op_branch   = 7'b1100011;
    localparam logic [6:0] c_op_load     = 7'b0000011;
    localparam logic [6:0] c_op_store    = 7'b0100011;
    localparam logic [6:0] c_op_op_imm   = 7'b0010011;
    localparam logic [6:0] c_op_op       = 7'b0110011;
    localparam logic [6:0] c_op_op_imm32 = 7'b0011011;
    localparam logic [6:0] c_op_op32     = 7'b0111011;
    localparam logic [6:0] c_op_misc_mem = 7'b0001111;
    localparam logic [6:0] c_op_system   = 7'b1110011;

    function automatic fmt_e decode_fmt(input logic [6:0] opcode);
        case (opcode)
            c_op_op, c_op_op32:                  return c_fmt_r;
            c_op_op_imm, c_op_op_imm32, c_op_load,
            c_op_jalr, c_op_misc_mem, c_op_system: return c_fmt_i;
            c_op_store:                          return c_fmt_s;
            c_op_branch:                         return c_fmt_b;
            c_op_lui, c_op_auipc:                return c_fmt_u;
            c_op_jal:                            return c_fmt_j;
            default:                             return c_fmt_ill;
        endcase
    endfunction

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    function automatic bit nr_regs_legal(input int nr_regs);
        return (nr_regs == 16) || (nr_regs == 32);
    endfunction

    function automatic bit idx_in_range(input logic [4:0] idx, input int nr_regs);
        return int'(idx) < nr_regs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx22041405_idu_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx22041405_idu_pipe_if                                                   |
// | Fetch, issue and write-back signals of the decode stage.                   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface ysyx22041405_idu_pipe_if
    import ysyx22041405_idu_pipe_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [4:0]      out_rd;
    logic            out_rd_we;
    logic [2:0]      out_fmt;

    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd, wb_data, flush,
        output in_ready, out_valid, out_pc, out_imm, out_rs1_data, out_rs2_data,
               out_rd, out_rd_we, out_fmt
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd, wb_data, flush,
        input  in_ready, out_valid, out_pc, out_imm, out_rs1_data, out_rs2_data,
               out_rd, out_rd_we, out_fmt
    );
endinterface
`default_nettype wire

// File: rtl/ysyx22041405_idu_pipe_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx22041405_regfile                                                       |
// | NR_REGS x XLEN register file, two async reads, one write, x0 hardwired.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module ysyx22041405_regfile
    import ysyx22041405_idu_pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NR_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      i_raddr1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata
);
    localparam int c_aw = $clog2(NR_REGS);

    logic [XLEN-1:0] r_mem [NR_REGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0) && idx_in_range(i_waddr, NR_REGS)) begin
            r_mem[i_waddr[c_aw-1:0]] <= i_wdata;
        end
    end

    // Out-of-range indices read as zero so they can never alias a real register.
    assign o_rdata1 = ((i_raddr1 != 5'd0) && idx_in_range(i_raddr1, NR_REGS))
                    ? r_mem[i_raddr1[c_aw-1:0]] : '0;
    assign o_rdata2 = ((i_raddr2 != 5'd0) && idx_in_range(i_raddr2, NR_REGS))
                    ? r_mem[i_raddr2[c_aw-1:0]] : '0;

endmodule
`default_nettype wire

// File: rtl/ysyx22041405_idu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx22041405_idu_pipe                                                      |
// | One-entry decode stage: decode, immediate, register read, busy scoreboard. |
// | Define YSYX22041405_IDU_WB_BYPASS_EN to forward same-cycle write-back.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module ysyx22041405_idu_pipe
    import ysyx22041405_idu_pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NR_REGS = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx22041405_idu_pipe_if.slave bus
);
    localparam int c_aw = $clog2(NR_REGS);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("ysyx22041405_idu_pipe: XLEN must be 32 or 64");
    end
    if (!nr_regs_legal(NR_REGS)) begin : g_bad_nr_regs
        $error("ysyx22041405_idu_pipe: NR_REGS must be 16 or 32");
    end

    logic               r_full;
    logic [31:0]        r_inst;
    logic [XLEN-1:0]    r_pc;
    logic [NR_REGS-1:0] r_busy;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    fmt_e            w_fmt_dec;
    fmt_e            w_fmt;
    logic            w_src_bad;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_rd_we;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rf_rs1;
    logic [XLEN-1:0] w_rf_rs2;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_busy_rs1;
    logic            w_busy_rs2;
    logic            w_hazard;
    logic            w_out_valid;
    logic            w_issue;
    logic            w_in_ready;
    logic            w_load;

    assign w_opcode = r_inst[6:0];
    assign w_rd     = r_inst[11:7];
    assign w_rs1    = r_inst[19:15];
    assign w_rs2    = r_inst[24:20];

    always_comb begin
        w_fmt_dec = decode_fmt(w_opcode);
        w_src_bad = 1'b0;
        if ((w_fmt_dec inside {c_fmt_r, c_fmt_i, c_fmt_s, c_fmt_b}) &&
            !idx_in_range(w_rs1, NR_REGS)) begin
            w_src_bad = 1'b1;
        end
        if ((w_fmt_dec inside {c_fmt_r, c_fmt_s, c_fmt_b}) &&
            !idx_in_range(w_rs2, NR_REGS)) begin
            w_src_bad = 1'b1;
        end
        w_fmt     = w_src_bad ? c_fmt_ill : w_fmt_dec;
        w_use_rs1 = w_fmt inside {c_fmt_r, c_fmt_i, c_fmt_s, c_fmt_b};
        w_use_rs2 = w_fmt inside {c_fmt_r, c_fmt_s, c_fmt_b};
        w_rd_we   = (w_fmt inside {c_fmt_r, c_fmt_i, c_fmt_u, c_fmt_j}) && (w_rd != 5'd0);
    end

    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            c_fmt_i: w_imm32 = {{20{r_inst[31]}}, r_inst[31:20]};
            c_fmt_s: w_imm32 = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
            c_fmt_b: w_imm32 = {{19{r_inst[31]}}, r_inst[31], r_inst[7],
                                r_inst[30:25], r_inst[11:8], 1'b0};
            c_fmt_u: w_imm32 = {r_inst[31:12], 12'b0};
            c_fmt_j: w_imm32 = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12],
                                r_inst[20], r_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    if (XLEN > 32) begin : g_imm_sext
        assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_imm_native
        assign w_imm = w_imm32;
    end

    ysyx22041405_regfile #(
        .XLEN    (XLEN),
        .NR_REGS (NR_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rf_rs1),
        .o_rdata2 (w_rf_rs2),
        .i_we     (bus.wb_valid),
        .i_waddr  (bus.wb_rd),
        .i_wdata  (bus.wb_data)
    );

`ifdef YSYX22041405_IDU_WB_BYPASS_EN
    logic w_wb_hit1;
    logic w_wb_hit2;

    // A write-back landing on a busy source this cycle both clears the hazard and supplies the value.
    always_comb begin
        w_wb_hit1  = bus.wb_valid && (bus.wb_rd == w_rs1) && (w_rs1 != 5'd0);
        w_wb_hit2  = bus.wb_valid && (bus.wb_rd == w_rs2) && (w_rs2 != 5'd0);
        w_busy_rs1 = r_busy[w_rs1[c_aw-1:0]] && !w_wb_hit1;
        w_busy_rs2 = r_busy[w_rs2[c_aw-1:0]] && !w_wb_hit2;
        w_rs1_data = w_wb_hit1 ? bus.wb_data : w_rf_rs1;
        w_rs2_data = w_wb_hit2 ? bus.wb_data : w_rf_rs2;
    end
`else
    always_comb begin
        w_busy_rs1 = r_busy[w_rs1[c_aw-1:0]];
        w_busy_rs2 = r_busy[w_rs2[c_aw-1:0]];
        w_rs1_data = w_rf_rs1;
        w_rs2_data = w_rf_rs2;
    end
`endif

    assign w_hazard    = (w_use_rs1 && w_busy_rs1) || (w_use_rs2 && w_busy_rs2);
    assign w_out_valid = r_full && !w_hazard;
    assign w_issue     = w_out_valid && bus.out_ready;
    assign w_in_ready  = !bus.flush && (!r_full || w_issue);
    assign w_load      = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_inst <= '0;
            r_pc   <= '0;
        end else if (bus.flush) begin
            r_full <= 1'b0;
        end else if (w_load) begin
            r_full <= 1'b1;
            r_inst <= bus.in_inst;
            r_pc   <= bus.in_pc;
        end else if (w_issue) begin
            r_full <= 1'b0;
        end
    end

    // Set is tested first so an issue and a write-back to the same register leave it busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NR_REGS; i++) begin
                if (w_issue && w_rd_we && (w_rd == 5'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (bus.wb_valid && (bus.wb_rd == 5'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_pc       = r_pc;
    assign bus.out_imm      = w_imm;
    assign bus.out_rs1_data = w_rs1_data;
    assign bus.out_rs2_data = w_rs2_data;
    assign bus.out_rd       = w_rd;
    assign bus.out_rd_we    = w_rd_we;
    assign bus.out_fmt      = w_fmt;

endmodule
`default_nettype wire

// File: tb/tb_ysyx22041405_idu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ysyx22041405_idu_pipe                                                   |
// | Directed bench: a 64-bit/32-reg stage and a 32-bit/16-reg stage.           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_ysyx22041405_idu_pipe;

    localparam logic [31:0] c_addi1 = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] c_add2  = 32'h0010_8133; // add  x2,x1,x1
    localparam logic [31:0] c_sw    = 32'hFE10_2E23; // sw   x1,-4(x0)
    localparam logic [31:0] c_beq   = 32'hFE00_0CE3; // beq  x0,x0,-8
    localparam logic [31:0] c_lui5  = 32'hFFFF_F2B7; // lui  x5,0xFFFFF
    localparam logic [31:0] c_addi3 = 32'h0010_0193; // addi x3,x0,1
    localparam logic [31:0] c_add4  = 32'h0001_8233; // add  x4,x3,x0
    localparam logic [31:0] c_add6  = 32'h0002_0333; // add  x6,x4,x0
    localparam logic [31:0] c_add20 = 32'h000A_00B3; // add  x1,x20,x0
    localparam logic [31:0] c_addm1 = 32'hFFF0_0093; // addi x1,x0,-1

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ysyx22041405_idu_pipe_if #(.XLEN(64)) bus_a ();
    ysyx22041405_idu_pipe_if #(.XLEN(32)) bus_b ();

    ysyx22041405_idu_pipe #(.XLEN(64), .NR_REGS(32)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    ysyx22041405_idu_pipe #(.XLEN(32), .NR_REGS(16)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        bus_a.in_valid = 0; bus_a.in_inst = '0; bus_a.in_pc = '0; bus_a.out_ready = 0;
        bus_a.wb_valid = 0; bus_a.wb_rd = '0; bus_a.wb_data = '0; bus_a.flush = 0;
        bus_b.in_valid = 0; bus_b.in_inst = '0; bus_b.in_pc = '0; bus_b.out_ready = 0;
        bus_b.wb_valid = 0; bus_b.wb_rd = '0; bus_b.wb_data = '0; bus_b.flush = 0;

        // Reset
        tick(); tick();
        rst = 1;
        settle();
        chk("rst_out_valid", bus_a.out_valid, 0);
        chk("rst_in_ready", bus_a.in_ready, 1);

        // addi x1,x0,5
        bus_a.in_valid = 1; bus_a.in_inst = c_addi1; bus_a.in_pc = 64'h8000_0000;
        bus_a.out_ready = 1;
        tick();
        settle();
        chk("addi_valid", bus_a.out_valid, 1);
        chk("addi_imm", bus_a.out_imm, 5);
        chk("addi_fmt", bus_a.out_fmt, 1);
        chk("addi_rd", bus_a.out_rd, 1);
        chk("addi_rd_we", bus_a.out_rd_we, 1);
        chk("addi_pc", bus_a.out_pc, 64'h8000_0000);
        chk("addi_rs1", bus_a.out_rs1_data, 0);

        // add x2,x1,x1 behind the in-flight addi x1
        bus_a.in_inst = c_add2; bus_a.in_pc = 64'h8000_0004;
        tick();
        bus_a.in_valid = 0;
        settle();
        chk("add_stall_valid", bus_a.out_valid, 0);
        chk("add_stall_in_ready", bus_a.in_ready, 0);
        chk("add_fmt", bus_a.out_fmt, 0);
        chk("add_rd", bus_a.out_rd, 2);
        tick();
        settle();
        chk("add_still_stalled", bus_a.out_valid, 0);

        bus_a.wb_valid = 1; bus_a.wb_rd = 1; bus_a.wb_data = 7;
        settle();
`ifdef YSYX22041405_IDU_WB_BYPASS_EN
        chk("add_byp_valid", bus_a.out_valid, 1);
        chk("add_byp_rs1", bus_a.out_rs1_data, 7);
        chk("add_byp_rs2", bus_a.out_rs2_data, 7);
        tick();
        bus_a.wb_valid = 0;
        settle();
        chk("add_drained", bus_a.out_valid, 0);
`else
        chk("add_wb_cycle_valid", bus_a.out_valid, 0);
        tick();
        bus_a.wb_valid = 0;
        settle();
        chk("add_after_wb_valid", bus_a.out_valid, 1);
        chk("add_after_wb_rs1", bus_a.out_rs1_data, 7);
        chk("add_after_wb_rs2", bus_a.out_rs2_data, 7);
        tick();
        settle();
        chk("add_drained", bus_a.out_valid, 0);
`endif

        // Back-pressure: sw held three cycles, beq waiting behind it
        bus_a.out_ready = 0;
        bus_a.in_valid = 1; bus_a.in_inst = c_sw; bus_a.in_pc = 64'h8000_0008;
        tick();
        bus_a.in_inst = c_beq; bus_a.in_pc = 64'h8000_000C;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) tick();
            settle();
            chk("sw_hold_valid", bus_a.out_valid, 1);
            chk("sw_hold_in_ready", bus_a.in_ready, 0);
            chk("sw_hold_imm", bus_a.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
            chk("sw_hold_pc", bus_a.out_pc, 64'h8000_0008);
        end
        chk("sw_fmt", bus_a.out_fmt, 2);
        chk("sw_rd_we", bus_a.out_rd_we, 0);
        bus_a.out_ready = 1;
        settle();
        chk("sw_release_in_ready", bus_a.in_ready, 1);
        tick();
        bus_a.in_inst = c_lui5; bus_a.in_pc = 64'h8000_0010;
        settle();
        chk("beq_valid", bus_a.out_valid, 1);
        chk("beq_fmt", bus_a.out_fmt, 3);
        chk("beq_imm", bus_a.out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("beq_pc", bus_a.out_pc, 64'h8000_000C);

        // lui x5 sign-extends to 64 bits
        tick();
        bus_a.in_inst = c_addi3; bus_a.in_pc = 64'h8000_0014;
        settle();
        chk("lui_imm", bus_a.out_imm, 64'hFFFF_FFFF_FFFF_F000);
        chk("lui_fmt", bus_a.out_fmt, 4);
        chk("lui_rd", bus_a.out_rd, 5);
        chk("lui_rd_we", bus_a.out_rd_we, 1);

        // addi x3 issues in the same cycle as a write-back to x3
        tick();
        bus_a.in_inst = c_add4; bus_a.in_pc = 64'h8000_0018;
        bus_a.wb_valid = 1; bus_a.wb_rd = 3; bus_a.wb_data = 64'h55;
        settle();
        chk("addi3_valid", bus_a.out_valid, 1);
        chk("addi3_rd", bus_a.out_rd, 3);
        tick();
        bus_a.in_valid = 0; bus_a.wb_valid = 0;
        settle();
        chk("set_wins_stall", bus_a.out_valid, 0);
        tick();
        settle();
        chk("set_wins_stall2", bus_a.out_valid, 0);

        // Flush over a stalled add x4 with a simultaneous offer
        bus_a.out_ready = 0; bus_a.flush = 1;
        bus_a.in_valid = 1; bus_a.in_inst = c_addi1;
        settle();
        chk("flush_in_ready", bus_a.in_ready, 0);
        tick();
        bus_a.flush = 0; bus_a.in_valid = 0;
        settle();
        chk("flush_out_valid", bus_a.out_valid, 0);
        chk("flush_empty", bus_a.in_ready, 1);

        bus_a.in_valid = 1; bus_a.in_inst = c_add4;
        tick();
        bus_a.in_valid = 0;
        settle();
        chk("flush_keeps_busy", bus_a.out_valid, 0);

        bus_a.wb_valid = 1; bus_a.wb_rd = 3; bus_a.wb_data = 9; bus_a.out_ready = 1;
        settle();
`ifdef YSYX22041405_IDU_WB_BYPASS_EN
        chk("add4_valid", bus_a.out_valid, 1);
        chk("add4_rs1", bus_a.out_rs1_data, 9);
        tick();
        bus_a.wb_valid = 0;
`else
        tick();
        bus_a.wb_valid = 0;
        settle();
        chk("add4_valid", bus_a.out_valid, 1);
        chk("add4_rs1", bus_a.out_rs1_data, 9);
`endif
        tick();
        bus_a.in_valid = 1; bus_a.in_inst = c_add6;
        tick();
        bus_a.in_valid = 0;
        settle();
        chk("add6_stall", bus_a.out_valid, 0);
        chk("add6_rd", bus_a.out_rd, 6);

        // Reset in the middle of the stall
        rst = 0;
        tick();
        rst = 1;
        settle();
        chk("midrst_out_valid", bus_a.out_valid, 0);
        chk("midrst_in_ready", bus_a.in_ready, 1);
        bus_a.in_valid = 1; bus_a.in_inst = c_add4;
        tick();
        bus_a.in_valid = 0;
        settle();
        chk("midrst_busy_cleared", bus_a.out_valid, 1);
        chk("midrst_rf_cleared", bus_a.out_rs1_data, 0);

        // NR_REGS=16: source beyond the file is illegal but passes through
        bus_b.out_ready = 1;
        bus_b.in_valid = 1; bus_b.in_inst = c_add20; bus_b.in_pc = 32'h0000_1000;
        tick();
        bus_b.in_inst = c_addm1;
        settle();
        chk("x20_valid", bus_b.out_valid, 1);
        chk("x20_fmt", bus_b.out_fmt, 7);
        chk("x20_rd_we", bus_b.out_rd_we, 0);
        chk("x20_imm", bus_b.out_imm, 0);
        chk("x20_in_ready", bus_b.in_ready, 1);
        tick();
        bus_b.in_valid = 0;
        settle();
        chk("b_addi_imm", bus_b.out_imm, 64'h0000_0000_FFFF_FFFF);
        chk("b_addi_fmt", bus_b.out_fmt, 1);
        chk("b_addi_rd_we", bus_b.out_rd_we, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
